// File: rtl/io_timer_pkg.sv
// io_timer_pkg: shared definitions for the io_timer block.
//   - register offsets within the 4-address window
//   - CTRL / STAT bit positions
//   - prescaler select encoding and its terminal-count function
package io_timer_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_COUNT = 2'd1;
  localparam logic [1:0] REG_CMP   = 2'd2;
  localparam logic [1:0] REG_STAT  = 2'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_CTC    = 1;
  localparam int unsigned CTRL_IE     = 2;
  localparam int unsigned CTRL_PS_LSB = 3;
  localparam int unsigned CTRL_PS_MSB = 4;
  localparam int unsigned CTRL_POL    = 5;

  localparam int unsigned STAT_OVF  = 0;
  localparam int unsigned STAT_CMPF = 1;

  typedef enum logic [1:0] {
    PS_DIV1    = 2'd0,
    PS_DIV8    = 2'd1,
    PS_DIV64   = 2'd2,
    PS_DIV1024 = 2'd3
  } ps_e;

  // Last prescaler value before a tick (divide ratio minus one).
  function automatic int unsigned ps_terminal(input ps_e ps);
    int unsigned term;
    term = 0;
    unique case (ps)
      PS_DIV1:    term = 0;
      PS_DIV8:    term = 7;
      PS_DIV64:   term = 63;
      PS_DIV1024: term = 1023;
    endcase
    return term;
  endfunction

endpackage

// File: rtl/io_timer_prescaler.sv
// io_timer_prescaler: free-running divider producing the counter tick.
//   clk, rst : clock, asynchronous active-high reset
//   en       : run enable; low holds the divider at 0
//   ps       : divide select (/1, /8, /64, /1024)
//   tick     : high for the one cycle the divider sits on its terminal value
module io_timer_prescaler
  import io_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  ps_e  ps,
  output logic tick
);

  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] term;

  assign term = PRESCALE_W'(ps_terminal(ps));
  // >= rather than == so that lowering PS below the current count still
  // wraps on the next compare instead of running to the top of the range.
  assign tick = en && (cnt >= term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/io_timer.sv
// io_timer: memory-mapped 8-bit timer/counter on the CPU IO bus.
//   clk, reset     : clock, asynchronous active-high reset
//   address        : CPU bus address; block decodes BASE_ADDR+0..3
//   din            : CPU write data
//   write_en       : CPU write strobe
//   read_en        : CPU read strobe
//   dout           : registered read data, 0 when not addressed last cycle
//   interrupt      : level IRQ, IE && (OVF || CMPF)
//   interrupt_clr  : one-cycle clear pulse, clears OVF and CMPF
//   pwm_out        : registered PWM output (only with IO_TIMER_PWM_EN)
// Registers: 0 CTRL {POL,PS[1:0],IE,CTC,EN}, 1 COUNT, 2 CMP, 3 STAT {CMPF,OVF} (W1C).
// Build option: define IO_TIMER_PWM_EN to add pwm_out and CTRL[5] (POL).
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h1010,
  parameter int unsigned PRESCALE_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  din,
  input  logic        write_en,
  input  logic        read_en,
  output logic [7:0]  dout,
  output logic        interrupt,
  input  logic        interrupt_clr
`ifdef IO_TIMER_PWM_EN
  ,
  output logic        pwm_out
`endif
);

`ifdef IO_TIMER_PWM_EN
  localparam logic [7:0] CTRL_WMASK = 8'h3F;
`else
  localparam logic [7:0] CTRL_WMASK = 8'h1F;
`endif

  logic [7:0] ctrl;
  logic [7:0] count;
  logic [7:0] cmp;
  logic       ovf;
  logic       cmpf;

  logic       hit;
  logic [1:0] offset;
  logic       wr_ctrl, wr_count, wr_cmp, wr_stat;
  logic       tick, tick_eff, match;
  logic       ovf_set, cmpf_set, ovf_clr, cmpf_clr;
  logic [7:0] rd_data;

  assign hit    = address[15:2] == BASE_ADDR[15:2];
  assign offset = address[1:0];

  always_comb begin
    wr_ctrl  = 1'b0;
    wr_count = 1'b0;
    wr_cmp   = 1'b0;
    wr_stat  = 1'b0;
    if (write_en && hit) begin
      unique case (offset)
        REG_CTRL:  wr_ctrl  = 1'b1;
        REG_COUNT: wr_count = 1'b1;
        REG_CMP:   wr_cmp   = 1'b1;
        REG_STAT:  wr_stat  = 1'b1;
      endcase
    end
  end

  io_timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk (clk),
    .rst (reset),
    .en  (ctrl[CTRL_EN]),
    .ps  (ps_e'(ctrl[CTRL_PS_MSB:CTRL_PS_LSB])),
    .tick(tick)
  );

  // A CPU write to COUNT swallows a coincident tick, including its flag sets.
  assign tick_eff = tick && !wr_count;
  assign match    = count == cmp;
  assign cmpf_set = tick_eff && match;
  assign ovf_set  = tick_eff && !(ctrl[CTRL_CTC] && match) && (count == 8'hFF);
  assign ovf_clr  = (wr_stat && din[STAT_OVF]) || interrupt_clr;
  assign cmpf_clr = (wr_stat && din[STAT_CMPF]) || interrupt_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
      cmp  <= '0;
    end else begin
      if (wr_ctrl) ctrl <= din & CTRL_WMASK;
      if (wr_cmp)  cmp  <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (wr_count) begin
      count <= din;
    end else if (tick) begin
      if (ctrl[CTRL_CTC] && match) count <= '0;
      else                         count <= count + 8'd1;
    end
  end

  // Hardware set dominates any clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf  <= 1'b0;
      cmpf <= 1'b0;
    end else begin
      ovf  <= ovf_set  || (ovf  && !ovf_clr);
      cmpf <= cmpf_set || (cmpf && !cmpf_clr);
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (offset)
      REG_CTRL:  rd_data = ctrl;
      REG_COUNT: rd_data = count;
      REG_CMP:   rd_data = cmp;
      REG_STAT:  rd_data = {6'b0, cmpf, ovf};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else if (read_en && hit) begin
      dout <= rd_data;
    end else begin
      dout <= '0;
    end
  end

  assign interrupt = ctrl[CTRL_IE] && (ovf || cmpf);

`ifdef IO_TIMER_PWM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= ((count < cmp) && ctrl[CTRL_EN]) ^ ctrl[CTRL_POL];
    end
  end
`endif

endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: self-checking bench for io_timer.
// Directed register-level scenarios followed by randomized bus traffic,
// all compared against an integer-level reference model of the timer.
// Honours IO_TIMER_PWM_EN the same way as the design.
`timescale 1ns/1ps
module tb_io_timer;

  localparam logic [15:0] BASE = 16'h1010;
`ifdef IO_TIMER_PWM_EN
  localparam int CTRL_MASK = 'h3F;
`else
  localparam int CTRL_MASK = 'h1F;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  din;
  logic        write_en;
  logic        read_en;
  logic [7:0]  dout;
  logic        interrupt;
  logic        interrupt_clr;
`ifdef IO_TIMER_PWM_EN
  logic        pwm_out;
`endif

  io_timer #(
    .BASE_ADDR (BASE),
    .PRESCALE_W(10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .din          (din),
    .write_en     (write_en),
    .read_en      (read_en),
    .dout         (dout),
    .interrupt    (interrupt),
    .interrupt_clr(interrupt_clr)
`ifdef IO_TIMER_PWM_EN
    ,
    .pwm_out      (pwm_out)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: whole-register integers, prescaler as a phase counter
  // against the divide ratio.
  int m_ctrl, m_count, m_cmp, m_ovf, m_cmpf, m_phase;
  int exp_dout, exp_irq, exp_pwm;
  int div_tab[4] = '{1, 8, 64, 1024};

  task automatic model_reset();
    m_ctrl = 0; m_count = 0; m_cmp = 0; m_ovf = 0; m_cmpf = 0; m_phase = 0;
    exp_dout = 0; exp_irq = 0; exp_pwm = 0;
  endtask

  task automatic model_step();
    int c_ctrl  = m_ctrl;
    int c_count = m_count;
    int c_cmp   = m_cmp;
    int c_ovf   = m_ovf;
    int c_cmpf  = m_cmpf;
    int off     = int'(address[1:0]);
    int en      = (c_ctrl >> 0) & 1;
    int ctc     = (c_ctrl >> 1) & 1;
    int pol     = (c_ctrl >> 5) & 1;
    int ps      = (c_ctrl >> 3) & 3;
    int hit     = (address[15:2] == BASE[15:2]) ? 1 : 0;
    int wr      = (write_en && hit) ? 1 : 0;
    int tick    = 0;
    int set_ovf = 0;
    int set_cmpf = 0;

    if (en != 0) begin
      m_phase++;
      if (m_phase >= div_tab[ps]) begin
        m_phase = 0;
        tick = 1;
      end
    end else begin
      m_phase = 0;
    end

    exp_dout = 0;
    if (read_en && hit != 0) begin
      case (off)
        0: exp_dout = c_ctrl;
        1: exp_dout = c_count;
        2: exp_dout = c_cmp;
        default: exp_dout = c_cmpf * 2 + c_ovf;
      endcase
    end
    exp_pwm = (((c_count < c_cmp) && en != 0) ? 1 : 0) ^ pol;

    if (tick != 0 && !(wr != 0 && off == 1)) begin
      if (c_count == c_cmp) set_cmpf = 1;
      if (ctc != 0 && c_count == c_cmp) m_count = 0;
      else if (c_count == 255) begin m_count = 0; set_ovf = 1; end
      else m_count = c_count + 1;
    end

    m_ovf = c_ovf;
    m_cmpf = c_cmpf;
    if ((wr != 0 && off == 3 && din[0]) || interrupt_clr) m_ovf = 0;
    if ((wr != 0 && off == 3 && din[1]) || interrupt_clr) m_cmpf = 0;
    if (set_ovf != 0)  m_ovf = 1;
    if (set_cmpf != 0) m_cmpf = 1;

    if (wr != 0) begin
      case (off)
        0: m_ctrl  = int'(din) & CTRL_MASK;
        1: m_count = int'(din);
        2: m_cmp   = int'(din);
        default: ;
      endcase
    end
    exp_irq = (((m_ctrl >> 2) & 1) != 0 && (m_ovf != 0 || m_cmpf != 0)) ? 1 : 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("dout", 32'(dout), exp_dout);
    check("interrupt", 32'(interrupt), exp_irq);
`ifdef IO_TIMER_PWM_EN
    check("pwm_out", 32'(pwm_out), exp_pwm);
`endif
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address = a; din = d; write_en = 1'b1;
    cyc();
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    address = a; read_en = 1'b1;
    cyc();
    read_en = 1'b0;
    d = dout;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] seq_exp[5];
    int hi_cnt;

    reset = 1'b1; address = '0; din = '0; write_en = 1'b0; read_en = 1'b0;
    interrupt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_irq", 32'(interrupt), 0);
    check("reset_dout", 32'(dout), 0);
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 16'(i), d);
      check("reset_reg", 32'(d), 0);
    end

    // Overflow at /1
    wr(BASE + 16'd1, 8'hFD);
    wr(BASE + 16'd0, 8'h05);
    seq_exp[0] = 8'hFD; seq_exp[1] = 8'hFE; seq_exp[2] = 8'hFF; seq_exp[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 16'd1, d);
      check("ovf_count_seq", 32'(d), 32'(seq_exp[i]));
    end
    check("ovf_irq", 32'(interrupt), 1);
    rd(BASE + 16'd3, d);
    check("ovf_flag", 32'(d & 8'h01), 1);
    wr(BASE + 16'd0, 8'h00);
    wr(BASE + 16'd3, 8'h03);
    check("w1c_irq_low", 32'(interrupt), 0);

    // Clear on compare
    wr(BASE + 16'd1, 8'h00);
    wr(BASE + 16'd2, 8'h03);
    wr(BASE + 16'd0, 8'h07);
    seq_exp[0] = 8'h00; seq_exp[1] = 8'h01; seq_exp[2] = 8'h02; seq_exp[3] = 8'h03;
    seq_exp[4] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      rd(BASE + 16'd1, d);
      check("ctc_count_seq", 32'(d), 32'(seq_exp[i]));
    end
    check("ctc_irq", 32'(interrupt), 1);
    wr(BASE + 16'd0, 8'h06);
    check("ctc_irq_held", 32'(interrupt), 1);
    interrupt_clr = 1'b1;
    cyc();
    interrupt_clr = 1'b0;
    check("irq_clr_low", 32'(interrupt), 0);

    // Divide by 8 over 64 clocks
    wr(BASE + 16'd0, 8'h00);
    wr(BASE + 16'd1, 8'h00);
    wr(BASE + 16'd3, 8'h03);
    wr(BASE + 16'd0, 8'h09);
    repeat (64) cyc();
    wr(BASE + 16'd0, 8'h00);
    rd(BASE + 16'd1, d);
    check("div8_count", 32'(d), 8);

    // W1C of OVF on the same edge OVF sets
    wr(BASE + 16'd3, 8'h03);
    wr(BASE + 16'd1, 8'hFE);
    wr(BASE + 16'd0, 8'h01);
    cyc();
    wr(BASE + 16'd3, 8'h01);
    rd(BASE + 16'd3, d);
    check("w1c_vs_set", 32'(d & 8'h01), 1);

    // COUNT write on a tick edge
    wr(BASE + 16'd1, 8'h40);
    rd(BASE + 16'd1, d);
    check("count_wr_wins", 32'(d), 32'h40);
    wr(BASE + 16'd0, 8'h00);

    // Out-of-window reads
    rd(BASE + 16'd4, d);
    check("oow_read_hi", 32'(d), 0);
    rd(BASE - 16'd1, d);
    check("oow_read_lo", 32'(d), 0);

`ifdef IO_TIMER_PWM_EN
    wr(BASE + 16'd2, 8'h80);
    wr(BASE + 16'd0, 8'h01);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      if (pwm_out) hi_cnt++;
    end
    check("pwm_duty_128", 32'(hi_cnt), 128);
    wr(BASE + 16'd0, 8'h00);
`else
    hi_cnt = 0;
    wr(BASE + 16'd0, 8'hFF);
    rd(BASE + 16'd0, d);
    check("ctrl_pol_absent", 32'(d), 32'h1F);
    wr(BASE + 16'd0, 8'h00);
`endif

    // Asynchronous reset mid-count with the interrupt asserted
    wr(BASE + 16'd3, 8'h03);
    wr(BASE + 16'd1, 8'hFE);
    wr(BASE + 16'd0, 8'h05);
    repeat (3) cyc();
    check("pre_reset_irq", 32'(interrupt), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_irq", 32'(interrupt), 0);
    check("async_reset_dout", 32'(dout), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 16'(i), d);
      check("post_reset_reg", 32'(d), 0);
    end

    // Randomized bus traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) address = 16'($urandom);
      else address = BASE + 16'($urandom_range(0, 3));
      din = 8'($urandom);
      if (address[1:0] == 2'd0 && $urandom_range(0, 3) != 0) din[4] = 1'b0;
      write_en = ($urandom_range(0, 3) == 0);
      read_en = ($urandom_range(0, 1) == 0);
      interrupt_clr = ($urandom_range(0, 15) == 0);
      cyc();
    end
    write_en = 1'b0; read_en = 1'b0; interrupt_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
